// File: rtl/uart_pkg.sv
// Shared types and constants for the fractional UART baud generator:
// configuration record, reset defaults, minimum clamps and the clamp helper.
package uart_pkg;

  localparam int CFG_DIV_INT_W  = 16;
  localparam int CFG_DIV_FRAC_W = 4;
  localparam int CFG_PRESC_W    = 6;

  localparam int RST_DIV_INT  = 651;
  localparam int RST_DIV_FRAC = 1;
  localparam int RST_PRESCALE = 16;

  localparam int MIN_DIV_INT  = 2;
  localparam int MIN_PRESCALE = 4;

  typedef struct packed {
    logic [CFG_DIV_INT_W-1:0]  div_int;
    logic [CFG_DIV_FRAC_W-1:0] div_frac;
    logic [CFG_PRESC_W-1:0]    prescale;
  } baud_cfg_t;

  // Raises too-small divisors/prescales so a period can never collapse below the minimum.
  function automatic baud_cfg_t clamp_cfg(input baud_cfg_t raw);
    baud_cfg_t res;
    res = raw;
    if (raw.div_int < CFG_DIV_INT_W'(MIN_DIV_INT)) begin
      res.div_int = CFG_DIV_INT_W'(MIN_DIV_INT);
    end else begin
      res.div_int = raw.div_int;
    end
    if (raw.prescale < CFG_PRESC_W'(MIN_PRESCALE)) begin
      res.prescale = CFG_PRESC_W'(MIN_PRESCALE);
    end else begin
      res.prescale = raw.prescale;
    end
    return res;
  endfunction

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control/configuration and tick bus between the UART FSMs (master) and the
// fractional baud generator (slave).
interface uart_baud_gen_frac_if #(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 4,
  parameter int PRESC_W    = 6
);
  logic                  en;
  logic                  cfg_load;
  logic [DIV_INT_W-1:0]  cfg_div_int;
  logic [DIV_FRAC_W-1:0] cfg_div_frac;
  logic [PRESC_W-1:0]    cfg_prescale;
  logic                  rx_resync;
  logic                  tx_tick;
  logic                  rx_os_tick;
  logic                  rx_mid;
  logic                  rx_bit_end;
  logic                  cfg_pending;

  modport master (
    output en, cfg_load, cfg_div_int, cfg_div_frac, cfg_prescale, rx_resync,
    input  tx_tick, rx_os_tick, rx_mid, rx_bit_end, cfg_pending
  );

  modport slave (
    input  en, cfg_load, cfg_div_int, cfg_div_frac, cfg_prescale, rx_resync,
    output tx_tick, rx_os_tick, rx_mid, rx_bit_end, cfg_pending
  );
endinterface

// File: rtl/uart_baud_engine.sv
// One timing chain: fractional period counter plus oversample counter.
// The carry from the fractional accumulator stretches the following period by one cycle.
module uart_baud_engine
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  baud_cfg_t              cfg,
  output logic                   tick,
  output logic [CFG_PRESC_W-1:0] cnt
);

  logic [CFG_DIV_INT_W:0]  pc_r;
  logic [CFG_DIV_INT_W:0]  period_last_s;
  logic [CFG_DIV_FRAC_W-1:0] acc_r;
  logic                    c_r;
  logic [CFG_PRESC_W-1:0]  cnt_r;
  logic [CFG_DIV_FRAC_W:0] frac_sum_s;

  assign period_last_s = {1'b0, cfg.div_int} + (CFG_DIV_INT_W+1)'(c_r)
                         - (CFG_DIV_INT_W+1)'(1);
  assign frac_sum_s    = {1'b0, acc_r} + {1'b0, cfg.div_frac};
  // >= rather than == so a period shortened by a config change cannot wrap.
  assign tick          = en && !clear && (pc_r >= period_last_s);
  assign cnt           = cnt_r;

  // Period counter, fractional accumulator and oversample counter.
  always_ff @(posedge clk) begin
    if (!rst || !en || clear) begin
      pc_r  <= '0;
      acc_r <= '0;
      c_r   <= 1'b0;
      cnt_r <= '0;
    end else if (tick) begin
      pc_r         <= '0;
      {c_r, acc_r} <= frac_sum_s;
      if (cnt_r >= cfg.prescale - CFG_PRESC_W'(1)) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CFG_PRESC_W'(1);
      end
    end else begin
      pc_r <= pc_r + (CFG_DIV_INT_W+1)'(1);
    end
  end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: independent TX/RX tick chains, clamped
// runtime configuration that is swapped in on a TX bit boundary while running.
module uart_baud_gen_frac #(
  parameter int DIV_INT_W    = 16,
  parameter int DIV_FRAC_W   = 4,
  parameter int PRESC_W      = 6,
  parameter int RST_DIV_INT  = 651,
  parameter int RST_DIV_FRAC = 1,
  parameter int RST_PRESCALE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_baud_gen_frac_if.slave  bif
);
  import uart_pkg::*;

  baud_cfg_t              active_r;
  baud_cfg_t              shadow_r;
  baud_cfg_t              cfg_in_s;
  baud_cfg_t              rst_cfg_s;
  logic                   pending_r;
  logic                   tx_eng_tick_s;
  logic                   rx_eng_tick_s;
  logic                   tx_tick_s;
  logic [CFG_PRESC_W-1:0] tx_cnt_s;
  logic [CFG_PRESC_W-1:0] rx_cnt_s;
  logic [CFG_PRESC_W-1:0] last_os_s;
  logic [CFG_PRESC_W-1:0] mid_os_s;

  assign cfg_in_s.div_int   = bif.cfg_div_int;
  assign cfg_in_s.div_frac  = bif.cfg_div_frac;
  assign cfg_in_s.prescale  = bif.cfg_prescale;
  assign rst_cfg_s.div_int  = DIV_INT_W'(RST_DIV_INT);
  assign rst_cfg_s.div_frac = DIV_FRAC_W'(RST_DIV_FRAC);
  assign rst_cfg_s.prescale = PRESC_W'(RST_PRESCALE);

  // Active prescale is clamped to >= 4, so neither subtraction can underflow.
  assign last_os_s = active_r.prescale - CFG_PRESC_W'(1);
  assign mid_os_s  = (active_r.prescale >> 1) - CFG_PRESC_W'(1);

  uart_baud_engine u_tx_engine (
    .clk   (clk),
    .rst   (rst),
    .en    (bif.en),
    .clear (1'b0),
    .cfg   (active_r),
    .tick  (tx_eng_tick_s),
    .cnt   (tx_cnt_s)
  );

  uart_baud_engine u_rx_engine (
    .clk   (clk),
    .rst   (rst),
    .en    (bif.en),
    .clear (bif.rx_resync),
    .cfg   (active_r),
    .tick  (rx_eng_tick_s),
    .cnt   (rx_cnt_s)
  );

  assign tx_tick_s       = tx_eng_tick_s && (tx_cnt_s >= last_os_s);
  assign bif.tx_tick     = tx_tick_s;
  assign bif.rx_os_tick  = rx_eng_tick_s;
  assign bif.rx_mid      = rx_eng_tick_s && (rx_cnt_s == mid_os_s);
  assign bif.rx_bit_end  = rx_eng_tick_s && (rx_cnt_s >= last_os_s);
  assign bif.cfg_pending = pending_r;

  // Active/shadow configuration; a new load always wins over applying the old shadow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active_r  <= clamp_cfg(rst_cfg_s);
      shadow_r  <= '0;
      pending_r <= 1'b0;
    end else if (bif.cfg_load && !bif.en) begin
      active_r  <= clamp_cfg(cfg_in_s);
      pending_r <= 1'b0;
    end else if (bif.cfg_load) begin
      shadow_r  <= cfg_in_s;
      pending_r <= 1'b1;
    end else if (pending_r && (!bif.en || tx_tick_s)) begin
      active_r  <= clamp_cfg(shadow_r);
      pending_r <= 1'b0;
    end else begin
      pending_r <= pending_r;
    end
  end

endmodule
